// File: rtl/link_pkg.sv
// Shared definitions for the router link transmit path: flit framing bit
// positions, framing FSM encoding and default credit depth.
package link_pkg;

  // Framing bits are counted down from the flit MSB: idx = buffer_width - X_BIT.
  localparam int HEAD_BIT = 1;
  localparam int TAIL_BIT = 2;

  localparam int DEFAULT_CREDIT_DEPTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/link_tx_if.sv
// Flit path of a router output port: show-ahead buffer side plus link side.
interface link_tx_if #(
  parameter int buffer_width = 64
);

  logic [buffer_width-1:0] in;
  logic                    empty;
  logic                    consume;
  logic [buffer_width-1:0] out_flit;
  logic                    out_valid;
  logic                    credit_in;

  modport slave (
    input  in, empty, credit_in,
    output consume, out_flit, out_valid
  );

  modport master (
    output in, empty, credit_in,
    input  consume, out_flit, out_valid
  );

endinterface

// File: rtl/credit_counter.sv
// Up/down credit counter that saturates at depth and latches a sticky flag
// when a credit is returned into an already full counter.
module credit_counter #(
  parameter int depth = 8,
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [width-1:0] count,
  output logic             overflow
);

  localparam logic [width-1:0] FULL = width'(depth);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end else if (inc && !dec) begin
      if (count == FULL) overflow <= 1'b1;
      else               count    <= count + 1'b1;
    end
  end

endmodule

// File: rtl/link_tx.sv
// Transmit end of a router output port: pops the show-ahead buffer, checks
// packet framing and drives registered flits under credit flow control.
module link_tx
  import link_pkg::*;
#(
  parameter int buffer_width = 64,
  parameter int credit_depth = DEFAULT_CREDIT_DEPTH,
  parameter int credit_width = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  link_tx_if.slave                lnk,
  output logic [credit_width-1:0] credits,
  output logic [15:0]             pkt_count,
  output logic                    err_framing,
  output logic                    err_credit
);

  state_t state;
  logic   head, tail;
  logic   send_ok, drop_ok, send;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    head         = lnk.in[buffer_width-HEAD_BIT];
    tail         = lnk.in[buffer_width-TAIL_BIT];
    send_ok      = (credits != '0);
    drop_ok      = (state == IDLE) && !head;
    lnk.consume  = rst && !lnk.empty && (send_ok || drop_ok);
    send         = lnk.consume && !drop_ok;
  end

  credit_counter #(
    .depth (credit_depth),
    .width (credit_width)
  ) u_credits (
    .clk      (clk),
    .rst      (rst),
    .inc      (lnk.credit_in),
    .dec      (send),
    .count    (credits),
    .overflow (err_credit)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      lnk.out_flit <= '0;
      lnk.out_valid <= 1'b0;
      pkt_count    <= '0;
      err_framing  <= 1'b0;
    end else begin
      lnk.out_valid <= send;
      if (send) lnk.out_flit <= lnk.in;

      if (lnk.consume) begin
        unique case (state)
          IDLE: begin
            if (!head)     err_framing <= 1'b1;
            else if (tail) pkt_count   <= pkt_count + 16'd1;
            else           state       <= PKT;
          end
          PKT: begin
            if (head) begin
              // A stray head restarts framing; the broken packet is not counted.
              err_framing <= 1'b1;
              state       <= tail ? IDLE : PKT;
            end else if (tail) begin
              state     <= IDLE;
              pkt_count <= pkt_count + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
